// File: rtl/alu_ctrl_if.sv
// Host bus and ALU-side signals of the ALU sequencing controller.
// master = system/host side (operands, commands, ALU result); slave = controller.
interface alu_ctrl_if #(
  parameter int N = 8
);
  logic [N-1:0] bus_in;
  logic         load_a;
  logic         load_b;
  logic         load_a_res;
  logic         start;
  logic [2:0]   op;
  logic         ready;
  logic         done;
  logic         error;
  logic         alu_enable;
  logic [2:0]   alu_mode;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_out;
  logic         alu_zero;
  logic [N-1:0] result;
  logic         flag_zero;

  modport master (
    output bus_in, load_a, load_b, load_a_res, start, op, alu_out, alu_zero,
    input  ready, done, error, alu_enable, alu_mode, alu_a, alu_b, result, flag_zero
  );

  modport slave (
    input  bus_in, load_a, load_b, load_a_res, start, op, alu_out, alu_zero,
    output ready, done, error, alu_enable, alu_mode, alu_a, alu_b, result, flag_zero
  );
endinterface

// File: rtl/alu_ctrl.sv
// Sequences one operation on an external registered ALU: load operands,
// issue for one cycle, capture the result, then pulse done.
module alu_ctrl #(
  parameter int N = 8
) (
  input  logic     clk,
  input  logic     reset,
  alu_ctrl_if.slave bus
);
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_INC = 3'd5;
  localparam logic [2:0] ALU_DEC = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DONE
  } state_t;

  state_t       state;
  state_t       state_next;

  logic [N-1:0] reg_a;
  logic [N-1:0] reg_b;
  logic [N-1:0] result_q;
  logic [2:0]   mode_q;
  logic         flag_zero_q;
  logic         error_q;

  logic         op_valid;
  logic         accept;
  logic         reject;
  logic         ready_c;
  logic         enable_c;
  logic         done_c;
  logic         capture_c;

  // The ALU zero flag is observed but the captured flag is derived from alu_out.
  logic         unused_alu_zero;
  assign unused_alu_zero = bus.alu_zero;

  always_comb begin
    op_valid = bus.op inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
                              ALU_XOR, ALU_INC, ALU_DEC};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready_c    = 1'b0;
    enable_c   = 1'b0;
    done_c     = 1'b0;
    capture_c  = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) begin
          if (op_valid) begin
            accept     = 1'b1;
            state_next = ISSUE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ISSUE: begin
        enable_c   = 1'b1;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        capture_c  = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand loads are only honoured while ready, so operands stay frozen
  // for the whole operation; the accumulate path has priority over bus_in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_a       <= '0;
      reg_b       <= '0;
      result_q    <= '0;
      mode_q      <= '0;
      flag_zero_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      error_q <= reject;
      if (ready_c) begin
        if (bus.load_a_res) begin
          reg_a <= result_q;
        end else if (bus.load_a) begin
          reg_a <= bus.bus_in;
        end
        if (bus.load_b) begin
          reg_b <= bus.bus_in;
        end
      end
      if (accept) begin
        mode_q <= bus.op;
      end
      if (capture_c) begin
        result_q    <= bus.alu_out;
        flag_zero_q <= (bus.alu_out == '0);
      end
    end
  end

  assign bus.ready      = ready_c;
  assign bus.done       = done_c;
  assign bus.error      = error_q;
  assign bus.alu_enable = enable_c;
  assign bus.alu_mode   = mode_q;
  assign bus.alu_a      = reg_a;
  assign bus.alu_b      = reg_b;
  assign bus.result     = result_q;
  assign bus.flag_zero  = flag_zero_q;
endmodule
